// File: rtl/sr_pulse_conditioner.sv
// ============================================================================
// sr_pulse_conditioner
// ----------------------------------------------------------------------------
// Turns two raw, asynchronous, active-high push buttons into clean debounced
// levels and single-cycle rising-edge strobes. The strobes are meant to drive
// an edge-sampled set/reset storage element directly.
//
// The set and reset paths are two instances of the same channel and share no
// state. When both strobes qualify on the same edge, both are asserted together.
// Priority between set and reset is left to the consumer.
//
// Ports (top level):
//   clk          in   sole clock, everything updates on the rising edge
//   rst          in   synchronous, active-high reset
//   btn_set      in   raw asynchronous set button
//   btn_reset    in   raw asynchronous reset button
//   set_pulse    out  one-cycle strobe on the debounced rising edge of btn_set
//   reset_pulse  out  one-cycle strobe on the debounced rising edge of btn_reset
//   set_level    out  debounced level of btn_set
//   reset_level  out  debounced level of btn_reset
//
// Parameters:
//   DEBOUNCE_CYCLES  number of consecutive cycles the synchronized input must
//                    differ from the debounced level before the level follows.
//                    Legal range is 2..65535.
//   CNT_W            debounce counter width. It must be able to hold
//                    DEBOUNCE_CYCLES-1.
//
// This block has no valid/ready handshakes. The strobes are plain
// one-cycle qualifiers with no back-pressure.
//
// Timing: a button change that is stable across edge E0 first reaches q1 at E0
// and q2 at E0+1. The counter then runs from E0+2 to E0+DEBOUNCE_CYCLES, and
// level/pulse update at E0+DEBOUNCE_CYCLES+1.
// ============================================================================

// ----------------------------------------------------------------------------
// sr_pulse_channel
// One conditioning channel: a 2-flop synchronizer, a saturating debounce
// counter, and a two-state level FSM with a registered rising-edge strobe.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous, active-high reset
//   btn    in   raw asynchronous button
//   level  out  debounced level. This is the FSM state itself, so it doubles
//               as the channel's state debug view (0 = ST_LOW, 1 = ST_HIGH).
//   pulse  out  registered one-cycle strobe on a LOW->HIGH level transition
// ----------------------------------------------------------------------------
module sr_pulse_channel #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic pulse
);

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } chan_state_t;

    // Terminal count: the last value the counter may hold.
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    // Synchronizer. Only q2 is ever looked at by the debounce logic.
    logic q1;
    logic q2;

    chan_state_t      state;
    chan_state_t      next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;
    logic             pulse_q;
    logic             next_pulse;
    logic             differs;

    // ------------------------------------------------------------------------
    // State register. Reset wins over everything: any partial count is thrown
    // away, and a strobe that would have fired on this edge is suppressed.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            q1      <= 1'b0;
            q2      <= 1'b0;
            state   <= ST_LOW;
            count   <= '0;
            pulse_q <= 1'b0;
        end else begin
            q1      <= btn;
            q2      <= q1;
            state   <= next_state;
            count   <= next_count;
            pulse_q <= next_pulse;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and counter logic.
    // The counter runs only while q2 disagrees with the current level. Any
    // agreement resets it, so a short excursion leaves no residue. At the
    // terminal count the level follows q2 and the counter restarts from zero.
    // The terminal test uses ">=" so that an out-of-range counter value can
    // only ever lead back to zero. It can never increment past TERM or wrap.
    // ------------------------------------------------------------------------
    assign differs = (q2 != (state == ST_HIGH));

    always_comb begin
        next_state = state;
        next_count = count;
        next_pulse = 1'b0;

        if (!differs) begin
            next_count = '0;
        end else if (count >= TERM) begin
            next_count = '0;
            next_state = q2 ? ST_HIGH : ST_LOW;
            // Only a LOW->HIGH transition produces a strobe. Because differs
            // is true here, q2 == 1 implies that the current state is ST_LOW.
            next_pulse = q2;
        end else begin
            next_count = count + ONE;
        end
    end

    assign level = (state == ST_HIGH);
    assign pulse = pulse_q;

    // Structural invariants. They are cheap to bind to and document intent.
    a_count_bounded : assert property (@(posedge clk) disable iff (rst)
        count <= TERM);
    a_pulse_implies_level : assert property (@(posedge clk) disable iff (rst)
        pulse_q |-> (state == ST_HIGH));

endmodule

// ----------------------------------------------------------------------------
// Top level: two independent channels.
// ----------------------------------------------------------------------------
module sr_pulse_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_set,
    input  logic btn_reset,
    output logic set_pulse,
    output logic reset_pulse,
    output logic set_level,
    output logic reset_level
);

    sr_pulse_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_set_chan (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_set),
        .level (set_level),
        .pulse (set_pulse)
    );

    sr_pulse_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_reset_chan (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_reset),
        .level (reset_level),
        .pulse (reset_pulse)
    );

endmodule

// File: tb/tb_sr_pulse_conditioner.sv
// ============================================================================
// tb_sr_pulse_conditioner
// Directed bench for sr_pulse_conditioner with DEBOUNCE_CYCLES = 4. Inputs are
// driven, and outputs sampled, 1 ns after each rising edge. After the k-th tick
// following a button change, the outputs reflect edge E(k-1).
// ============================================================================
module tb_sr_pulse_conditioner;

    localparam int DC = 4;

    logic clk;
    logic rst;
    logic btn_set;
    logic btn_reset;
    logic set_pulse;
    logic reset_pulse;
    logic set_level;
    logic reset_level;

    int n_cmp;
    int n_fail;

    sr_pulse_conditioner #(
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_set     (btn_set),
        .btn_reset   (btn_reset),
        .set_pulse   (set_pulse),
        .reset_pulse (reset_pulse),
        .set_level   (set_level),
        .reset_level (reset_level)
    );

    // ------------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // ------------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------------
    task automatic test_reset();
        rst       = 1'b1;
        btn_set   = 1'b1;
        btn_reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({set_pulse, reset_pulse, set_level, reset_level} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: got %b required 0000", i,
                         {set_pulse, reset_pulse, set_level, reset_level});
            end
        end
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        tick();
        rst = 1'b0;
        idle(4);
        n_cmp++;
        if ({set_pulse, reset_pulse, set_level, reset_level} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_idle: got %b required 0000",
                     {set_pulse, reset_pulse, set_level, reset_level});
        end
    endtask

    // Rise at E5 with a single pulse. Release falls at R5 with no pulse.
    task automatic test_set_rise();
        logic exp_p, exp_l;
        btn_set = 1'b1;
        for (int e = 0; e < 10; e++) begin
            tick();
            exp_p = (e == 5);
            exp_l = (e >= 5);
            n_cmp++;
            if (set_pulse !== exp_p) begin
                n_fail++;
                $display("FAIL set_rise_pulse E%0d: got %b required %b", e, set_pulse, exp_p);
            end
            n_cmp++;
            if (set_level !== exp_l) begin
                n_fail++;
                $display("FAIL set_rise_level E%0d: got %b required %b", e, set_level, exp_l);
            end
            n_cmp++;
            if ({reset_pulse, reset_level} !== 2'b00) begin
                n_fail++;
                $display("FAIL set_rise_isolation E%0d: got %b required 00", e,
                         {reset_pulse, reset_level});
            end
        end
        btn_set = 1'b0;
        for (int e = 0; e < 8; e++) begin
            tick();
            exp_l = (e < 5);
            n_cmp++;
            if (set_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL set_fall_pulse R%0d: got %b required 0", e, set_pulse);
            end
            n_cmp++;
            if (set_level !== exp_l) begin
                n_fail++;
                $display("FAIL set_fall_level R%0d: got %b required %b", e, set_level, exp_l);
            end
        end
    endtask

    // 3-cycle press is rejected. A 4-cycle press is just long enough.
    task automatic test_glitch();
        btn_set = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        btn_set = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            n_cmp++;
            if ({set_pulse, set_level} !== 2'b00) begin
                n_fail++;
                $display("FAIL glitch3 t%0d: got pulse,level=%b required 00", e,
                         {set_pulse, set_level});
            end
        end
        // Four cycles high: q2 is high at E2..E5, so terminal count hits at E5.
        btn_set = 1'b1;
        for (int e = 0; e < 8; e++) begin
            if (e == 4) btn_set = 1'b0;
            tick();
            n_cmp++;
            if (set_pulse !== (e == 5)) begin
                n_fail++;
                $display("FAIL glitch4_pulse E%0d: got %b required %b", e, set_pulse, (e == 5));
            end
        end
        idle(10);
        n_cmp++;
        if (set_level !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch4_settle: got %b required 0", set_level);
        end
    endtask

    // Reset in the middle of a count discards it. The held button then fires
    // 6 edges after the reset releases.
    task automatic test_reset_abort();
        logic exp_p;
        btn_reset = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({set_pulse, reset_pulse, set_level, reset_level} !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_in_reset: got %b required 0000",
                     {set_pulse, reset_pulse, set_level, reset_level});
        end
        rst = 1'b0;
        for (int f = 0; f < 10; f++) begin
            tick();
            exp_p = (f == 5);
            n_cmp++;
            if (reset_pulse !== exp_p) begin
                n_fail++;
                $display("FAIL abort_repulse F%0d: got %b required %b", f, reset_pulse, exp_p);
            end
            n_cmp++;
            if (reset_level !== (f >= 5)) begin
                n_fail++;
                $display("FAIL abort_relevel F%0d: got %b required %b", f, reset_level, (f >= 5));
            end
        end
        idle(10);
        // Reset exactly on the edge a pulse is due (E5) suppresses it.
        btn_set = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        n_cmp++;
        if ({set_pulse, set_level} !== 2'b00) begin
            n_fail++;
            $display("FAIL suppress_due_pulse: got %b required 00", {set_pulse, set_level});
        end
        rst = 1'b0;
        for (int f = 0; f < 8; f++) begin
            tick();
            n_cmp++;
            if (set_pulse !== (f == 5)) begin
                n_fail++;
                $display("FAIL suppress_repulse F%0d: got %b required %b", f, set_pulse, (f == 5));
            end
        end
        idle(10);
    endtask

    task automatic test_simultaneous();
        logic [1:0] exp_pp;
        btn_set   = 1'b1;
        btn_reset = 1'b1;
        for (int e = 0; e < 8; e++) begin
            tick();
            exp_pp = (e == 5) ? 2'b11 : 2'b00;
            n_cmp++;
            if ({set_pulse, reset_pulse} !== exp_pp) begin
                n_fail++;
                $display("FAIL simultaneous E%0d: got %b required %b", e,
                         {set_pulse, reset_pulse}, exp_pp);
            end
        end
        idle(10);
    endtask

    task automatic test_hold();
        int pulses;
        pulses  = 0;
        btn_set = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (set_pulse === 1'b1) pulses++;
        end
        btn_set = 1'b0;
        for (int e = 0; e < 10; e++) begin
            tick();
            if (set_pulse === 1'b1) pulses++;
            n_cmp++;
            if (set_level !== (e < 5)) begin
                n_fail++;
                $display("FAIL hold_release_level R%0d: got %b required %b", e, set_level, (e < 5));
            end
        end
        n_cmp++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL hold_pulse_count: got %0d required 1", pulses);
        end
    endtask

    task automatic test_toggle();
        int pulses;
        int level_hits;
        pulses     = 0;
        level_hits = 0;
        for (int i = 0; i < 50; i++) begin
            btn_set = ~btn_set;
            tick();
            if (set_pulse !== 1'b0) pulses++;
            if (set_level !== 1'b0) level_hits++;
        end
        idle(4);
        n_cmp++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL toggle_pulses: got %0d required 0", pulses);
        end
        n_cmp++;
        if (level_hits != 0) begin
            n_fail++;
            $display("FAIL toggle_level: got %0d high cycles required 0", level_hits);
        end
    endtask

    // ------------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------------
    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        rst       = 1'b1;
        btn_set   = 1'b0;
        btn_reset = 1'b0;
        test_reset();
        test_set_rise();
        test_glitch();
        test_reset_abort();
        test_simultaneous();
        test_hold();
        test_toggle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
